// File: rtl/button_pkg.sv
// Shared state encoding and default hold-timing constants for the button event stage.
package button_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] PRESS = 2'b01;
  localparam logic [1:0] LONG  = 2'b10;

  localparam int DEF_DVSR      = 100000;
  localparam int DEF_LONG_MS   = 1000;
  localparam int DEF_REPEAT_MS = 200;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_PRESS = PRESS,
    S_LONG  = LONG
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_if.sv
// Debounced button level in, one-cycle user events and held level out.
interface button_event_if;
  logic db;
  logic press_tick;
  logic release_tick;
  logic short_press;
  logic long_press;
  logic repeat_tick;
  logic held;

  modport master (
    output db,
    input  press_tick, release_tick, short_press, long_press, repeat_tick, held
  );

  modport slave (
    input  db,
    output press_tick, release_tick, short_press, long_press, repeat_tick, held
  );
endinterface

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/short/long/repeat pulses.
// The hold prescaler restarts on every press so long_press timing is exact.
module button_event
  import button_pkg::*;
#(
  parameter int DVSR      = DEF_DVSR,
  parameter int LONG_MS   = DEF_LONG_MS,
  parameter int REPEAT_MS = DEF_REPEAT_MS
) (
  input  logic         clk,
  input  logic         reset,
  button_event_if.slave bus
);

  localparam int PRE_W = $clog2(DVSR);
  localparam int MS_W  = $clog2(max2(LONG_MS, REPEAT_MS) + 1);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DVSR - 1);
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
  localparam logic [MS_W-1:0]  LONG_LAST = MS_W'(LONG_MS - 1);
  localparam logic [MS_W-1:0]  REP_LAST  = MS_W'((REPEAT_MS == 0) ? 0 : REPEAT_MS - 1);
  localparam logic [MS_W-1:0]  MS_ONE    = MS_W'(1);

  state_e           r_state;
  logic             r_db_q;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [MS_W-1:0]  r_ms_cnt;
  logic             r_press_tick;
  logic             r_release_tick;
  logic             r_short_press;
  logic             r_long_press;
  logic             r_repeat_tick;
  logic             r_held;

  logic w_rise;
  logic w_fall;
  logic w_ms_tick;
  logic [PRE_W-1:0] w_pre_next;

  assign w_rise     = bus.db & ~r_db_q;
  assign w_fall     = ~bus.db & r_db_q;
  assign w_ms_tick  = (r_state != S_IDLE) && (r_pre_cnt == PRE_LAST);
  assign w_pre_next = (r_pre_cnt == PRE_LAST) ? '0 : r_pre_cnt + PRE_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_db_q         <= 1'b0;
      r_pre_cnt      <= '0;
      r_ms_cnt       <= '0;
      r_press_tick   <= 1'b0;
      r_release_tick <= 1'b0;
      r_short_press  <= 1'b0;
      r_long_press   <= 1'b0;
      r_repeat_tick  <= 1'b0;
      r_held         <= 1'b0;
    end else begin
      r_db_q         <= bus.db;
      r_press_tick   <= 1'b0;
      r_release_tick <= 1'b0;
      r_short_press  <= 1'b0;
      r_long_press   <= 1'b0;
      r_repeat_tick  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_held <= 1'b0;
          if (w_rise) begin
            r_state      <= S_PRESS;
            r_press_tick <= 1'b1;
            r_held       <= 1'b1;
            r_pre_cnt    <= '0;
            r_ms_cnt     <= '0;
          end
        end

        // Fall wins over the long threshold on the same edge.
        S_PRESS: begin
          r_pre_cnt <= w_pre_next;
          if (w_fall) begin
            r_state        <= S_IDLE;
            r_release_tick <= 1'b1;
            r_short_press  <= 1'b1;
            r_held         <= 1'b0;
          end else if (w_ms_tick) begin
            if (r_ms_cnt == LONG_LAST) begin
              r_state      <= S_LONG;
              r_long_press <= 1'b1;
              r_ms_cnt     <= '0;
            end else begin
              r_ms_cnt <= r_ms_cnt + MS_ONE;
            end
          end
        end

        S_LONG: begin
          r_pre_cnt <= w_pre_next;
          if (w_fall) begin
            r_state        <= S_IDLE;
            r_release_tick <= 1'b1;
            r_held         <= 1'b0;
          end else if (w_ms_tick) begin
            if ((REPEAT_MS != 0) && (r_ms_cnt == REP_LAST)) begin
              r_repeat_tick <= 1'b1;
              r_ms_cnt      <= '0;
            end else begin
              r_ms_cnt <= r_ms_cnt + MS_ONE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_tick   = r_press_tick;
  assign bus.release_tick = r_release_tick;
  assign bus.short_press  = r_short_press;
  assign bus.long_press   = r_long_press;
  assign bus.repeat_tick  = r_repeat_tick;
  assign bus.held         = r_held;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with DVSR=4, LONG_MS=3; instance A repeats every 2 ticks, B has repeat disabled.
module tb_button_event;

  logic clk;
  logic reset;
  logic r_db;

  button_event_if ifa ();
  button_event_if ifb ();

  assign ifa.db = r_db;
  assign ifb.db = r_db;

  button_event #(.DVSR(4), .LONG_MS(3), .REPEAT_MS(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  button_event #(.DVSR(4), .LONG_MS(3), .REPEAT_MS(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int cyc = 0;
  int n_press, n_rel, n_short, n_long, n_rep, nb_long, nb_rep, n_consec;
  int t_press, t_rel, t_long, t_rep1, t_rep2;
  logic p_press, p_rel, p_short, p_long, p_rep;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_rep = 0;
    nb_long = 0; nb_rep = 0;
    t_press = -1; t_rel = -1; t_long = -1; t_rep1 = -1; t_rep2 = -1;
  endtask

  always @(posedge clk) cyc++;

  // Event log, sampled on the falling edge.
  always @(negedge clk) begin
    if (ifa.press_tick)   begin n_press++; t_press = cyc; end
    if (ifa.release_tick) begin n_rel++;   t_rel   = cyc; end
    if (ifa.short_press)  n_short++;
    if (ifa.long_press)   begin n_long++;  t_long  = cyc; end
    if (ifa.repeat_tick) begin
      if (n_rep == 0) t_rep1 = cyc;
      else if (n_rep == 1) t_rep2 = cyc;
      n_rep++;
    end
    if (ifb.long_press)  nb_long++;
    if (ifb.repeat_tick) nb_rep++;
    if ((ifa.press_tick && p_press) || (ifa.release_tick && p_rel) ||
        (ifa.short_press && p_short) || (ifa.long_press && p_long) ||
        (ifa.repeat_tick && p_rep))
      n_consec++;
    p_press = ifa.press_tick;
    p_rel   = ifa.release_tick;
    p_short = ifa.short_press;
    p_long  = ifa.long_press;
    p_rep   = ifa.repeat_tick;
  end

  initial begin
    n_consec = 0;
    p_press = 0; p_rel = 0; p_short = 0; p_long = 0; p_rep = 0;
    clear_counts();
    reset = 1'b1;
    r_db  = 1'b0;

    // Reset state
    step(2);
    chk_eq("rst_press",   int'(ifa.press_tick),   0);
    chk_eq("rst_release", int'(ifa.release_tick), 0);
    chk_eq("rst_short",   int'(ifa.short_press),  0);
    chk_eq("rst_long",    int'(ifa.long_press),   0);
    chk_eq("rst_repeat",  int'(ifa.repeat_tick),  0);
    chk_eq("rst_held",    int'(ifa.held),         0);
    chk_eq("rst_held_b",  int'(ifb.held),         0);
    reset = 1'b0;
    step(2);

    // Short press: db high on 6 sampling edges
    clear_counts();
    r_db = 1'b1;
    step(1);
    chk_eq("sp_press_hi", int'(ifa.press_tick), 1);
    chk_eq("sp_held_hi",  int'(ifa.held),       1);
    step(1);
    chk_eq("sp_press_lo", int'(ifa.press_tick), 0);
    chk_eq("sp_held_on",  int'(ifa.held),       1);
    step(4);
    r_db = 1'b0;
    step(1);
    chk_eq("sp_release",  int'(ifa.release_tick), 1);
    chk_eq("sp_short",    int'(ifa.short_press),  1);
    chk_eq("sp_held_lo",  int'(ifa.held),         0);
    step(1);
    chk_eq("sp_release_lo", int'(ifa.release_tick), 0);
    step(2);
    chk_eq("sp_n_long",  n_long,  0);
    chk_eq("sp_n_short", n_short, 1);

    // Long press with repeat; B checks repeat disabled
    clear_counts();
    r_db = 1'b1;
    step(40);
    r_db = 1'b0;
    step(3);
    chk_eq("lp_n_press",   n_press, 1);
    chk_eq("lp_n_long",    n_long,  1);
    chk_eq("lp_long_dly",  t_long - t_press, 12);
    chk_eq("lp_rep1_dly",  t_rep1 - t_long,  8);
    chk_eq("lp_rep2_dly",  t_rep2 - t_long,  16);
    chk_eq("lp_n_rep",     n_rep,   3);
    chk_eq("lp_n_release", n_rel,   1);
    chk_eq("lp_n_short",   n_short, 0);
    chk_eq("norep_n_long", nb_long, 1);
    chk_eq("norep_n_rep",  nb_rep,  0);

    // Boundary: fall sampled on the threshold edge
    clear_counts();
    r_db = 1'b1;
    step(12);
    r_db = 1'b0;
    step(3);
    chk_eq("bnd0_n_short",   n_short, 1);
    chk_eq("bnd0_n_long",    n_long,  0);
    chk_eq("bnd0_n_release", n_rel,   1);

    // Boundary: fall one edge after the threshold
    clear_counts();
    r_db = 1'b1;
    step(13);
    r_db = 1'b0;
    step(3);
    chk_eq("bnd1_n_long",    n_long,  1);
    chk_eq("bnd1_n_short",   n_short, 0);
    chk_eq("bnd1_n_release", n_rel,   1);
    chk_eq("bnd1_rel_dly",   t_rel - t_long, 1);

    // Reset mid-hold, 5 cycles after long_press
    clear_counts();
    r_db = 1'b1;
    step(17);
    chk_eq("mid_long_seen", n_long, 1);
    reset = 1'b1;
    #1;
    chk_eq("mid_rst_held", int'(ifa.held),         0);
    chk_eq("mid_rst_rel",  int'(ifa.release_tick), 0);
    chk_eq("mid_rst_rep",  int'(ifa.repeat_tick),  0);
    step(1);
    reset = 1'b0;
    clear_counts();
    step(1);
    chk_eq("mid_press_hi", int'(ifa.press_tick), 1);
    chk_eq("mid_held_hi",  int'(ifa.held),       1);
    step(13);
    chk_eq("mid_n_release", n_rel,  0);
    chk_eq("mid_n_short",   n_short, 0);
    chk_eq("mid_long_dly",  t_long - t_press, 12);
    r_db = 1'b0;
    step(3);
    chk_eq("mid_final_rel", n_rel, 1);

    // Re-press one cycle after release
    clear_counts();
    r_db = 1'b1;
    step(3);
    r_db = 1'b0;
    step(1);
    r_db = 1'b1;
    step(3);
    r_db = 1'b0;
    step(3);
    chk_eq("repress_n_press", n_press, 2);
    chk_eq("repress_n_short", n_short, 2);

    chk_eq("no_consec_pulse", n_consec, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
